// File: rtl/des_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// des_round_sequencer_if
// Bundle of the sequencer's request inputs and the control outputs it drives
// toward the DES subkey generator and the Feistel datapath.
//   start, decrypt        : block request and mode (requester -> sequencer)
//   busy, done            : operation status
//   load_block, round_en,
//   last_round            : Feistel datapath strobes
//   round_count, key_count,
//   cnt_rollover,
//   key_rollover, reverse : subkey generator controls
// master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface des_round_sequencer_if;
    logic       start;
    logic       decrypt;
    logic       busy;
    logic       load_block;
    logic [4:0] round_count;
    logic [1:0] key_count;
    logic       cnt_rollover;
    logic       key_rollover;
    logic       reverse;
    logic       round_en;
    logic       last_round;
    logic       done;

    modport master (
        output start, decrypt,
        input  busy, load_block, round_count, key_count, cnt_rollover,
               key_rollover, reverse, round_en, last_round, done
    );

    modport slave (
        input  start, decrypt,
        output busy, load_block, round_count, key_count, cnt_rollover,
               key_rollover, reverse, round_en, last_round, done
    );
endinterface

// File: rtl/des_round_sequencer.sv
// ---------------------------------------------------------------------------
// des_round_sequencer
// Steps one block through a single-DES pass (TRIPLE=0) or an EDE triple-DES
// operation (TRIPLE=1, three passes). Drives the subkey generator counters
// and tells the Feistel datapath when to load, apply a round and finish.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset, abandons any in-flight block
//   bus  : des_round_sequencer_if.slave (start/decrypt in, controls out)
// Parameters:
//   NUM_ROUNDS : Feistel rounds per pass (1..31), round_count spans 0..NUM_ROUNDS
//   TRIPLE     : 1 = three passes (key_count 0,1,2), 0 = one pass
// ---------------------------------------------------------------------------
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16,
    parameter int TRIPLE     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    des_round_sequencer_if.slave        bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [4:0] LP_LAST_RC = 5'(NUM_ROUNDS);
    localparam logic [4:0] LP_PRE_RC  = 5'(NUM_ROUNDS - 1);
    localparam logic [1:0] LP_LAST_KC = (TRIPLE != 0) ? 2'd2 : 2'd0;

    logic [1:0] r_state;
    logic [4:0] r_round_count;
    logic [1:0] r_key_count;
    logic       r_decrypt;
    logic       r_busy;
    logic       r_load_block;
    logic       r_cnt_rollover;
    logic       r_key_rollover;
    logic       r_round_en;
    logic       r_last_round;
    logic       r_done;

    logic       w_run;
    logic       w_rc_last;
    logic       w_rc_pre;

    assign w_run     = (r_state == RUN);
    assign w_rc_last = (r_round_count == LP_LAST_RC);
    assign w_rc_pre  = (r_round_count == LP_PRE_RC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_round_count  <= 5'd0;
            r_key_count    <= 2'd0;
            r_decrypt      <= 1'b0;
            r_busy         <= 1'b0;
            r_load_block   <= 1'b0;
            r_cnt_rollover <= 1'b0;
            r_key_rollover <= 1'b0;
            r_round_en     <= 1'b0;
            r_last_round   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_load_block   <= 1'b0;
            r_cnt_rollover <= 1'b0;
            r_key_rollover <= 1'b0;
            r_done         <= 1'b0;
            // The subkey for round i is valid one cycle after round_count==i,
            // so the round strobe trails the counter by one cycle and skips
            // the key-load cycle (round_count==0).
            r_round_en     <= w_run && (r_round_count != 5'd0);
            r_last_round   <= w_run && w_rc_last;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state       <= RUN;
                        r_decrypt     <= bus.decrypt;
                        r_busy        <= 1'b1;
                        r_load_block  <= 1'b1;
                        r_round_count <= 5'd0;
                        r_key_count   <= 2'd0;
                    end
                end
                RUN: begin
                    if (w_rc_last) begin
                        // Key generator updates on this same edge, so the
                        // next pass loads its key at round_count==0.
                        r_round_count <= 5'd0;
                        if (r_key_count == LP_LAST_KC) begin
                            r_key_count <= 2'd0;
                            r_state     <= DRAIN;
                        end else begin
                            r_key_count <= r_key_count + 2'd1;
                        end
                    end else begin
                        r_round_count <= r_round_count + 5'd1;
                        // Rollover strobes are registered, so they are
                        // armed one count early to land on round_count==NUM_ROUNDS.
                        r_cnt_rollover <= w_rc_pre;
                        r_key_rollover <= w_rc_pre && (r_key_count == LP_LAST_KC);
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    // DONE: start is deliberately not sampled here.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.load_block   = r_load_block;
    assign bus.round_count  = r_round_count;
    assign bus.key_count    = r_key_count;
    assign bus.cnt_rollover = r_cnt_rollover;
    assign bus.key_rollover = r_key_rollover;
    assign bus.round_en     = r_round_en;
    assign bus.last_round   = r_last_round;
    assign bus.done         = r_done;
    // Middle pass of EDE runs the opposite direction of the outer passes.
    assign bus.reverse      = r_busy & (r_decrypt ^ (r_key_count == 2'd1));

endmodule

// File: tb/tb_des_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_des_round_sequencer
// Directed bench for des_round_sequencer: a TRIPLE=1 and a TRIPLE=0 instance
// share clock and reset; expected values come from the cycle index of each
// operation (17 cycles per pass for 16 rounds, then DRAIN and DONE).
// ---------------------------------------------------------------------------
module tb_des_round_sequencer;

    localparam int NR = 16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   sel;  // 0 = triple instance, 1 = single instance

    des_round_sequencer_if if3 ();
    des_round_sequencer_if if1 ();

    des_round_sequencer #(.NUM_ROUNDS(NR), .TRIPLE(1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    des_round_sequencer #(.NUM_ROUNDS(NR), .TRIPLE(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic       o_busy, o_load, o_cr, o_kr, o_rev, o_ren, o_lr, o_done;
    logic [4:0] o_rc;
    logic [1:0] o_kc;

    always_comb begin
        o_busy = if3.busy;        o_load = if3.load_block;
        o_rc   = if3.round_count; o_kc   = if3.key_count;
        o_cr   = if3.cnt_rollover; o_kr  = if3.key_rollover;
        o_rev  = if3.reverse;     o_ren  = if3.round_en;
        o_lr   = if3.last_round;  o_done = if3.done;
        if (sel) begin
            o_busy = if1.busy;        o_load = if1.load_block;
            o_rc   = if1.round_count; o_kc   = if1.key_count;
            o_cr   = if1.cnt_rollover; o_kr  = if1.key_rollover;
            o_rev  = if1.reverse;     o_ren  = if1.round_en;
            o_lr   = if1.last_round;  o_done = if1.done;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s, input bit d);
        if (sel) begin
            if1.start = s; if1.decrypt = d;
        end else begin
            if3.start = s; if3.decrypt = d;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},   32'(o_busy), 0);
        chk({tag, ".load"},   32'(o_load), 0);
        chk({tag, ".rc"},     32'(o_rc),   0);
        chk({tag, ".kc"},     32'(o_kc),   0);
        chk({tag, ".cr"},     32'(o_cr),   0);
        chk({tag, ".kr"},     32'(o_kr),   0);
        chk({tag, ".rev"},    32'(o_rev),  0);
        chk({tag, ".ren"},    32'(o_ren),  0);
        chk({tag, ".lr"},     32'(o_lr),   0);
        chk({tag, ".done"},   32'(o_done), 0);
    endtask

    // Presents start in an IDLE cycle and checks every cycle of the operation
    // plus the first IDLE cycle after done.
    task automatic run_op(input string name, input int passes, input bit dec, input bit hold);
        int R, lat, n_en, n_lr, n_cr, n_kr, pass, rc;
        bit e_ren, e_lr;
        string t;
        R = passes * (NR + 1);
        lat = -1; n_en = 0; n_lr = 0; n_cr = 0; n_kr = 0;
        set_start(1'b1, dec);
        tick();
        if (!hold) set_start(1'b0, 1'b0);
        for (int idx = 0; idx <= R + 1; idx++) begin
            if (idx < R) begin
                pass = idx / (NR + 1);
                rc   = idx % (NR + 1);
            end else begin
                pass = 0;
                rc   = 0;
            end
            e_ren = (idx >= 1) && (idx <= R) && (((idx - 1) % (NR + 1)) != 0);
            e_lr  = (idx >= 1) && (idx <= R) && (((idx - 1) % (NR + 1)) == NR);
            t = $sformatf("%s@%0d", name, idx);
            chk({t, ".busy"}, 32'(o_busy), 1);
            chk({t, ".load"}, 32'(o_load), 32'(idx == 0));
            chk({t, ".rc"},   32'(o_rc),   32'(rc));
            chk({t, ".kc"},   32'(o_kc),   32'(pass));
            chk({t, ".cr"},   32'(o_cr),   32'(idx < R && rc == NR));
            chk({t, ".kr"},   32'(o_kr),   32'(idx < R && rc == NR && pass == passes - 1));
            chk({t, ".rev"},  32'(o_rev),  32'(dec ^ (idx < R && pass == 1)));
            chk({t, ".ren"},  32'(o_ren),  32'(e_ren));
            chk({t, ".lr"},   32'(o_lr),   32'(e_lr));
            chk({t, ".done"}, 32'(o_done), 32'(idx == R + 1));
            if (o_ren === 1'b1) n_en++;
            if (o_lr  === 1'b1) n_lr++;
            if (o_cr  === 1'b1) n_cr++;
            if (o_kr  === 1'b1) n_kr++;
            if (o_done === 1'b1 && lat < 0) lat = idx + 1;
            tick();
        end
        chk({name, ".idle_busy"}, 32'(o_busy), 0);
        chk({name, ".idle_load"}, 32'(o_load), 0);
        chk({name, ".idle_done"}, 32'(o_done), 0);
        chk({name, ".latency"},   32'(lat),    (passes == 3) ? 53 : 19);
        chk({name, ".n_round_en"},  32'(n_en), 32'(passes * NR));
        chk({name, ".n_last_round"}, 32'(n_lr), 32'(passes));
        chk({name, ".n_cnt_roll"},  32'(n_cr), 32'(passes));
        chk({name, ".n_key_roll"},  32'(n_kr), 1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        sel = 1'b0;
        rst = 1'b1;
        if3.start = 1'b0; if3.decrypt = 1'b0;
        if1.start = 1'b0; if1.decrypt = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        sel = 1'b0;
        chk_idle("reset3");
        sel = 1'b1;
        chk_idle("reset1");

        // Triple DES: encrypt (E,D,E) and decrypt (D,E,D).
        sel = 1'b0;
        run_op("enc3", 3, 1'b0, 1'b0);
        run_op("dec3", 3, 1'b1, 1'b0);

        // start held high: ignored in DONE, accepted in the first IDLE cycle.
        run_op("hold3a", 3, 1'b1, 1'b1);
        run_op("hold3b", 3, 1'b0, 1'b0);

        // Reset mid-operation at round_count 9 of pass 1.
        set_start(1'b1, 1'b1);
        tick();
        set_start(1'b0, 1'b0);
        repeat (NR + 1 + 9) tick();
        chk("mid.rc",   32'(o_rc),   9);
        chk("mid.kc",   32'(o_kc),   1);
        chk("mid.rev",  32'(o_rev),  0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        run_op("after_rst", 3, 1'b0, 1'b0);

        // Single DES instance.
        sel = 1'b1;
        run_op("enc1", 1, 1'b0, 1'b0);
        run_op("dec1", 1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
